// File: rtl/cdc_hs_tx_pkg.sv
// Shared definitions for the two-phase handshake transmitter.
// State encoding and default payload width / ack timeout.
package cdc_hs_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 5;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/cdc_hs_tx_sync.sv
// Two-flop synchronizer for bringing asynchronous signals into the local clock domain.
module cdc_hs_tx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a two-phase req/ack handshake: holds a word stable for the far
// domain, waits for the synchronized ack, and flags acks that are overdue.
//
// state   | meaning
// IDLE    | no transfer pending, ready to accept a word
// WAIT    | word on tx_data, waiting for ack parity to match tx_req
module cdc_hs_tx
    import cdc_hs_tx_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             cdc_clk,
    input  logic             cdc_rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    input  logic             rx_ack,
    output logic             done,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_tx_data;
    logic [WIDTH-1:0] w_tx_data_nxt;
    logic             r_tx_req;
    logic             w_tx_req_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_timeout_err;
    logic             w_err_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_ack_s;
    logic             w_hit;

    cdc_hs_tx_sync #(
        .WIDTH (1)
    ) u_ack_sync (
        .i_clk   (cdc_clk),
        .i_rst_n (cdc_rstn),
        .i_d     (rx_ack),
        .o_q     (w_ack_s)
    );

    // Counter is about to reach TIMEOUT on this edge; an ack on the same edge
    // still completes the transfer, and the error is raised regardless.
    assign w_hit = (r_state == ST_WAIT) && (r_cnt == C_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_data_nxt = r_tx_data;
        w_tx_req_nxt  = r_tx_req;
        w_done_nxt    = 1'b0;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_tx_data_nxt = in_data;
                    w_tx_req_nxt  = ~r_tx_req;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt != C_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (w_ack_s == r_tx_req) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_err_nxt = r_timeout_err;
        if (w_hit) begin
            w_err_nxt = 1'b1;
        end else if (err_clr) begin
            w_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge cdc_clk or negedge cdc_rstn) begin
        if (!cdc_rstn) begin
            r_state       <= ST_IDLE;
            r_tx_data     <= '0;
            r_tx_req      <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_req      <= w_tx_req_nxt;
            r_done        <= w_done_nxt;
            r_timeout_err <= w_err_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign tx_data     = r_tx_data;
    assign tx_req      = r_tx_req;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx (WIDTH=5, TIMEOUT=8) with a transaction-level
// model of the handshake and a far-side responder.
module tb_cdc_hs_tx;

    localparam int W  = 5;
    localparam int TO = 8;

    logic         cdc_clk;
    logic         cdc_rstn;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [W-1:0] tx_data;
    logic         tx_req;
    logic         rx_ack;
    logic         done;
    logic         timeout_err;
    logic         err_clr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model of what the far domain should currently see.
    logic         m_parity = 1'b0;
    logic [W-1:0] m_data   = '0;

    cdc_hs_tx #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .cdc_clk     (cdc_clk),
        .cdc_rstn    (cdc_rstn),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .rx_ack      (rx_ack),
        .done        (done),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial begin
        cdc_clk = 1'b0;
        forever #5 cdc_clk = ~cdc_clk;
    end

    always @(posedge cdc_clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge cdc_clk);
        #1;
    endtask

    task automatic apply_reset();
        cdc_rstn = 1'b0;
        rx_ack   = 1'b0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        step();
        step();
        cdc_rstn = 1'b1;
        m_parity = 1'b0;
        m_data   = '0;
        step();
    endtask

    task automatic test_reset();
        cdc_rstn = 1'b0;
        rx_ack   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        err_clr  = 1'b0;
        step();
        step();
        tests++;
        if (in_ready !== 1'b1 || tx_req !== 1'b0 || tx_data !== '0 || done !== 1'b0 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_values got ready=%b req=%b data=%h done=%b err=%b exp 1 0 00 0 0",
                     in_ready, tx_req, tx_data, done, timeout_err);
        end
        cdc_rstn = 1'b1;
        step();
        step();
        tests++;
        if (in_ready !== 1'b1 || done !== 1'b0 || tx_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got ready=%b done=%b req=%b exp 1 0 0", in_ready, done, tx_req);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_data  = 5'h15;
        step();
        in_valid = 1'b0;
        m_parity = ~m_parity;
        m_data   = 5'h15;
        tests++;
        if (tx_data !== 5'h15 || tx_req !== m_parity || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_accept got data=%h req=%b ready=%b exp 15 %b 0", tx_data, tx_req, in_ready, m_parity);
        end
        step();
        step();
        tests++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL single_wait got ready=%b done=%b exp 0 0", in_ready, done);
        end
        rx_ack = m_parity;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++;
            if (done !== (i == 3)) begin
                fails++;
                $display("FAIL single_done edge=%0d got=%b exp=%b", i, done, (i == 3));
            end
        end
        tests++;
        if (in_ready !== 1'b1 || tx_data !== 5'h15) begin
            fails++;
            $display("FAIL single_end got ready=%b data=%h exp 1 15", in_ready, tx_data);
        end
    endtask

    // Cycle-driven traffic with a far-side responder that returns the ack
    // 'delay' cycles after seeing a new request (delay<0: random 0..4).
    task automatic run_traffic(input int n_words, input bit hold, input int delay, input bit rnd_words);
        int sent    = 0;
        int seen    = 0;
        int ack_at  = -1;
        int done_at = -1;
        int budget  = 0;
        bit m_busy  = 1'b0;
        int d;
        while (seen < n_words && budget < 2000) begin
            tests++;
            if (done !== (cyc == done_at)) begin
                fails++;
                $display("FAIL traffic_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == done_at));
            end
            if (cyc == done_at) begin
                seen++;
                m_busy = 1'b0;
            end
            tests++;
            if (in_ready !== !m_busy) begin
                fails++;
                $display("FAIL traffic_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !m_busy);
            end
            tests++;
            if (tx_req !== m_parity || tx_data !== m_data) begin
                fails++;
                $display("FAIL traffic_tx cyc=%0d got req=%b data=%h exp req=%b data=%h",
                         cyc, tx_req, tx_data, m_parity, m_data);
            end
            tests++;
            if (timeout_err !== 1'b0) begin
                fails++;
                $display("FAIL traffic_err cyc=%0d got=%b exp=0", cyc, timeout_err);
            end
            if (cyc == ack_at) begin
                rx_ack  = m_parity;
                done_at = cyc + 3;
            end
            if (sent < n_words && (hold || $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b1;
                in_data  = rnd_words ? W'($urandom) : W'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            if (!m_busy && in_valid) begin
                m_busy   = 1'b1;
                m_parity = ~m_parity;
                m_data   = in_data;
                sent++;
                d      = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
                ack_at = cyc + 1 + d;
            end
            step();
            budget++;
        end
        in_valid = 1'b0;
        tests++;
        if (seen != n_words || sent != n_words) begin
            fails++;
            $display("FAIL traffic_count got done=%0d sent=%0d exp %0d", seen, sent, n_words);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_traffic(3, 1'b1, 4, 1'b0);
        tests++;
        if (tx_req !== 1'b1 || tx_data !== 5'h03) begin
            fails++;
            $display("FAIL b2b_final got req=%b data=%h exp 1 03", tx_req, tx_data);
        end
    endtask

    task automatic test_random();
        run_traffic(24, 1'b0, -1, 1'b1);
    endtask

    task automatic test_spurious();
        rx_ack = ~rx_ack;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (done !== 1'b0 || in_ready !== 1'b1 || tx_req !== m_parity) begin
                fails++;
                $display("FAIL spurious_toggle got done=%b ready=%b req=%b exp 0 1 %b", done, in_ready, tx_req, m_parity);
            end
        end
        rx_ack = m_parity;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (done !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL spurious_restore got done=%b ready=%b exp 0 1", done, in_ready);
            end
        end
    endtask

    task automatic test_timeout();
        in_valid = 1'b1;
        in_data  = W'($urandom);
        step();
        in_valid = 1'b0;
        m_parity = ~m_parity;
        m_data   = in_data;
        for (int k = 1; k <= TO + 3; k++) begin
            step();
            tests++;
            if (timeout_err !== (k >= TO) || in_ready !== 1'b0 || tx_data !== m_data) begin
                fails++;
                $display("FAIL timeout_count k=%0d got err=%b ready=%b data=%h exp err=%b ready=0 data=%h",
                         k, timeout_err, in_ready, tx_data, (k >= TO), m_data);
            end
        end
        rx_ack = m_parity;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++;
            if (done !== (i == 3) || timeout_err !== 1'b1) begin
                fails++;
                $display("FAIL timeout_late_ack edge=%0d got done=%b err=%b exp done=%b err=1",
                         i, done, timeout_err, (i == 3));
            end
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear got=%b exp=0", timeout_err);
        end
    endtask

    // err_clr and the ack both land on the edge where the counter reaches TIMEOUT.
    task automatic test_collision();
        in_valid = 1'b1;
        in_data  = W'($urandom);
        step();
        in_valid = 1'b0;
        m_parity = ~m_parity;
        m_data   = in_data;
        for (int k = 1; k <= TO; k++) begin
            if (k == TO - 2) rx_ack = m_parity;
            if (k == TO) err_clr = 1'b1;
            step();
            tests++;
            if (timeout_err !== (k == TO) || done !== (k == TO) || in_ready !== (k == TO)) begin
                fails++;
                $display("FAIL collision k=%0d got err=%b done=%b ready=%b exp %b",
                         k, timeout_err, done, in_ready, (k == TO));
            end
        end
        err_clr = 1'b0;
        step();
        tests++;
        if (done !== 1'b0 || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL collision_after got done=%b err=%b exp 0 1", done, timeout_err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL collision_clear got=%b exp=0", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_data  = W'($urandom_range(1, 31));
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        cdc_rstn = 1'b0;
        rx_ack   = 1'b0;
        #1;
        tests++;
        if (tx_req !== 1'b0 || tx_data !== '0 || in_ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async got req=%b data=%h ready=%b done=%b exp 0 00 1 0",
                     tx_req, tx_data, in_ready, done);
        end
        step();
        step();
        cdc_rstn = 1'b1;
        m_parity = 1'b0;
        m_data   = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (done !== 1'b0 || in_ready !== 1'b1 || tx_req !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_after got done=%b ready=%b req=%b exp 0 1 0", done, in_ready, tx_req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_spurious();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
